// File: rtl/dma_read_engine_if.sv
// AXI4 read-channel bundle (AR + R) between the DMA read engine and memory.
// The master modport is the engine side, the slave modport the memory side.
interface dma_read_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arlen, arsize, arburst, arcache, arprot,
        output arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arcache, arprot,
        input  arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/dma_read_engine.sv
// AXI4 read DMA: fetches a linear buffer into the ingress FIFO using
// INCR bursts that stay inside 4 KB pages and never exceed 256 beats.
module dma_read_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [31:0]           i_total_len,
    output logic                  o_done,
    output logic                  o_error,
    output logic [DATA_WIDTH-1:0] o_fifo_wdata,
    output logic                  o_fifo_wen,
    input  logic                  i_fifo_full,
    dma_read_engine_if.master     m_axi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_done;
    logic                  r_error;
    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [31:0]           r_remaining;
    logic [31:0]           r_burst_bytes;
    logic [7:0]            r_beat_cnt;
    logic                  r_burst_err;

    logic [31:0] w_len_t;
    logic [12:0] w_dist;
    logic [31:0] w_min_rd;
    logic [31:0] w_bytes;
    logic        w_rready;
    logic        w_beat;
    logic        w_last;
    logic        w_resp_err;
    logic        w_last_err;

    assign w_len_t  = i_total_len & ~32'd3;
    assign w_dist   = 13'h1000 - {1'b0, r_cur_addr[11:0]};
    assign w_min_rd = (r_remaining < {19'd0, w_dist}) ?
                      r_remaining : {19'd0, w_dist};
    assign w_bytes  = (w_min_rd < 32'd1024) ? w_min_rd : 32'd1024;

    // R backpressure is combinational so a full FIFO stalls the same cycle
    assign w_rready   = (r_state == S_DATA) && !i_fifo_full;
    assign w_beat     = m_axi.rvalid && w_rready;
    assign w_last     = (r_beat_cnt == r_arlen);
    assign w_resp_err = (m_axi.rresp != 2'b00);
    assign w_last_err = (m_axi.rlast != w_last);

    assign m_axi.araddr  = r_araddr;
    assign m_axi.arlen   = r_arlen;
    assign m_axi.arsize  = 3'b010;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = w_rready;

    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_fifo_wen   = w_beat;
    assign o_fifo_wdata = m_axi.rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_cur_addr    <= '0;
            r_remaining   <= '0;
            r_burst_bytes <= '0;
            r_beat_cnt    <= '0;
            r_burst_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_error <= 1'b0;
                        if (i_base_addr[2:0] != 3'b000) begin
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_len_t == 32'd0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cur_addr  <= i_base_addr;
                            r_remaining <= w_len_t;
                            r_state     <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_burst_bytes <= w_bytes;
                    r_arlen       <= 8'((w_bytes >> 2) - 32'd1);
                    r_araddr      <= r_cur_addr;
                    r_beat_cnt    <= '0;
                    r_burst_err   <= 1'b0;
                    r_arvalid     <= 1'b1;
                    r_state       <= S_ADDR;
                end
                S_ADDR: begin
                    if (m_axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (w_resp_err || w_last_err) begin
                            r_error     <= 1'b1;
                            r_burst_err <= 1'b1;
                        end
                        // Termination follows the beat count, not rlast
                        if (w_last) begin
                            r_cur_addr  <= r_cur_addr + ADDR_WIDTH'(r_burst_bytes);
                            r_remaining <= r_remaining - r_burst_bytes;
                            if (r_remaining == r_burst_bytes || r_burst_err ||
                                w_resp_err || w_last_err) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_CALC;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
